// File: rtl/highpass_stream_filter.sv
// Streaming pass-band mask: accepts a frame of bin frequencies, compares LANES bins per
// cycle against a snapshot of the live cutoff config, and returns a pass mask plus popcount.
//
// state | meaning
// IDLE  | ready for a frame; recv_rdy high
// CALC  | evaluating LANES bins per cycle from the captured frame
// DONE  | result presented; held until send_rdy
module highpass_stream_filter #(
   parameter int                      BIT_WIDTH  = 32,
   parameter int                      DECIMAL_PT = 16,
   parameter int                      N_SAMPLES  = 8,
   parameter int                      LANES      = 2,
   parameter logic [BIT_WIDTH-1:0]    RESET_LO   = 1000,
   parameter logic [BIT_WIDTH-1:0]    RESET_HI   = '1
) (
   input  logic                             clk,
   input  logic                             reset,
   input  logic                             cfg_val,
   input  logic [1:0]                       cfg_mode,
   input  logic [BIT_WIDTH-1:0]             cfg_lo,
   input  logic [BIT_WIDTH-1:0]             cfg_hi,
   input  logic                             recv_val,
   output logic                             recv_rdy,
   input  logic [BIT_WIDTH-1:0]             recv_msg [N_SAMPLES-1:0],
   output logic                             send_val,
   input  logic                             send_rdy,
   output logic [N_SAMPLES-1:0]             send_mask,
   output logic [$clog2(N_SAMPLES+1)-1:0]   send_count
);

   localparam int STEPS = N_SAMPLES / LANES;
   localparam int IW    = (STEPS > 1) ? $clog2(STEPS) : 1;
   localparam int SW    = (N_SAMPLES > 1) ? $clog2(N_SAMPLES) : 1;
   localparam int CW    = $clog2(N_SAMPLES+1);

   if (N_SAMPLES % LANES != 0) begin : g_bad_lanes
      $error("N_SAMPLES must be a multiple of LANES");
   end
   if (DECIMAL_PT > BIT_WIDTH) begin : g_bad_point
      $error("DECIMAL_PT cannot exceed BIT_WIDTH");
   end

   typedef enum logic [1:0] {IDLE, CALC, DONE} state_t;

   state_t                 state_q;
   logic [IW-1:0]          idx_q;
   logic [1:0]             mode_q, snap_mode_q;
   logic [BIT_WIDTH-1:0]   lo_q, hi_q, snap_lo_q, snap_hi_q;
   logic [BIT_WIDTH-1:0]   freq_q [N_SAMPLES-1:0];
   logic [N_SAMPLES-1:0]   mask_q, mask_d;
   logic [CW-1:0]          count_q, count_d;
   logic                   recv_rdy_q, send_val_q;

   logic [SW-1:0]          bin_idx;
   logic [BIT_WIDTH-1:0]   bin_f;
   logic                   bin_pass;

   // Strict unsigned compare; bandpass with lo >= hi falls out as all-zero naturally.
   always_comb begin
      mask_d   = mask_q;
      count_d  = count_q;
      bin_idx  = '0;
      bin_f    = '0;
      bin_pass = 1'b0;
      for (int l = 0; l < LANES; l++) begin
         bin_idx = SW'(int'(idx_q) * LANES + l);
         bin_f   = freq_q[bin_idx];
         unique case (snap_mode_q)
            2'd0:    bin_pass = (bin_f > snap_lo_q);
            2'd1:    bin_pass = (bin_f < snap_hi_q);
            2'd2:    bin_pass = (bin_f > snap_lo_q) && (bin_f < snap_hi_q);
            default: bin_pass = 1'b1;
         endcase
         mask_d[bin_idx] = bin_pass;
         count_d         = count_d + CW'(bin_pass);
      end
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         state_q     <= IDLE;
         idx_q       <= '0;
         mode_q      <= 2'd0;
         lo_q        <= RESET_LO;
         hi_q        <= RESET_HI;
         snap_mode_q <= 2'd0;
         snap_lo_q   <= RESET_LO;
         snap_hi_q   <= RESET_HI;
         mask_q      <= '0;
         count_q     <= '0;
         recv_rdy_q  <= 1'b1;
         send_val_q  <= 1'b0;
      end else begin
         if (cfg_val) begin
            mode_q <= cfg_mode;
            lo_q   <= cfg_lo;
            hi_q   <= cfg_hi;
         end
         unique case (state_q)
            IDLE: begin
               if (recv_val) begin
                  // Snapshot takes the pre-write live values, so a same-cycle cfg_val
                  // only affects the following frame.
                  freq_q      <= recv_msg;
                  snap_mode_q <= mode_q;
                  snap_lo_q   <= lo_q;
                  snap_hi_q   <= hi_q;
                  mask_q      <= '0;
                  count_q     <= '0;
                  idx_q       <= '0;
                  recv_rdy_q  <= 1'b0;
                  state_q     <= CALC;
               end
            end
            CALC: begin
               mask_q  <= mask_d;
               count_q <= count_d;
               idx_q   <= idx_q + 1'b1;
               if (idx_q == IW'(STEPS-1)) begin
                  send_val_q <= 1'b1;
                  state_q    <= DONE;
               end
            end
            DONE: begin
               if (send_rdy) begin
                  send_val_q <= 1'b0;
                  recv_rdy_q <= 1'b1;
                  state_q    <= IDLE;
               end
            end
            default: state_q <= IDLE;
         endcase
      end
   end

   assign recv_rdy   = recv_rdy_q;
   assign send_val   = send_val_q;
   assign send_mask  = mask_q;
   assign send_count = count_q;

endmodule

// File: tb/tb_highpass_stream_filter.sv
// Bench for highpass_stream_filter: fixed vector table, hand sequences for config timing,
// backpressure and mid-frame reset, then random frames against a plain-arithmetic model.
module tb_highpass_stream_filter;

   typedef logic [31:0] frame_t [7:0];

   typedef struct {
      logic [1:0]  mode;
      logic [31:0] lo;
      logic [31:0] hi;
      frame_t      fr;
      logic [7:0]  emask;
      logic [3:0]  ecount;
   } vec_t;

   logic        clk = 1'b0;
   logic        reset;
   logic        cfg_val;
   logic [1:0]  cfg_mode;
   logic [31:0] cfg_lo, cfg_hi;
   logic        recv_val, recv_rdy;
   frame_t      recv_msg;
   logic        send_val, send_rdy;
   logic [7:0]  send_mask;
   logic [3:0]  send_count;

   int n_checks = 0;
   int n_pass   = 0;

   highpass_stream_filter dut (
      .clk        (clk),
      .reset      (reset),
      .cfg_val    (cfg_val),
      .cfg_mode   (cfg_mode),
      .cfg_lo     (cfg_lo),
      .cfg_hi     (cfg_hi),
      .recv_val   (recv_val),
      .recv_rdy   (recv_rdy),
      .recv_msg   (recv_msg),
      .send_val   (send_val),
      .send_rdy   (send_rdy),
      .send_mask  (send_mask),
      .send_count (send_count)
   );

   always #5 clk = ~clk;

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
      n_checks++;
      if (act === exp) n_pass++;
      else $display("FAIL %s: got %0h expected %0h", name, act, exp);
   endtask

   function automatic frame_t mkf(input logic [31:0] a0, a1, a2, a3, a4, a5, a6, a7);
      frame_t f;
      f[0] = a0; f[1] = a1; f[2] = a2; f[3] = a3;
      f[4] = a4; f[5] = a5; f[6] = a6; f[7] = a7;
      return f;
   endfunction

   // Reference: each bin judged independently from the pass rule; count is the popcount.
   task automatic model(input logic [1:0] mode, input logic [31:0] lo, input logic [31:0] hi,
                        input frame_t fr, output logic [7:0] m, output logic [3:0] c);
      longint f, l, h;
      m = '0;
      l = longint'(lo);
      h = longint'(hi);
      for (int i = 0; i < 8; i++) begin
         f = longint'(fr[i]);
         case (mode)
            2'd0: m[i] = (f > l);
            2'd1: m[i] = (f < h);
            2'd2: m[i] = (f > l) && (f < h);
            default: m[i] = 1'b1;
         endcase
      end
      c = 4'($countones(m));
   endtask

   task automatic do_cfg(input logic [1:0] mode, input logic [31:0] lo, input logic [31:0] hi);
      cfg_val = 1'b1; cfg_mode = mode; cfg_lo = lo; cfg_hi = hi;
      @(posedge clk); #1;
      cfg_val = 1'b0;
   endtask

   // Sends one frame, waits for the result, then completes the send handshake (send_rdy=1).
   task automatic run_frame(input frame_t fr, output logic [7:0] m, output logic [3:0] c,
                            output int lat);
      int n = 0;
      while (!recv_rdy && n < 50) begin @(posedge clk); #1; n++; end
      if (!recv_rdy) check("recv_rdy_timeout", 0, 1);
      recv_msg = fr;
      recv_val = 1'b1;
      @(posedge clk); #1;
      recv_val = 1'b0;
      cfg_val  = 1'b0;
      lat = 0;
      while (!send_val && lat < 50) begin @(posedge clk); #1; lat++; end
      if (!send_val) check("send_val_timeout", 0, 1);
      m = send_mask;
      c = send_count;
      send_rdy = 1'b1;
      @(posedge clk); #1;
   endtask

   vec_t        tbl [5];
   frame_t      f1, f2, fs, fr;
   logic [7:0]  m, em;
   logic [3:0]  c, ec;
   int          lat;
   logic [1:0]  rmode;
   logic [31:0] rlo, rhi;

   initial begin
      reset = 1'b1; cfg_val = 1'b0; cfg_mode = '0; cfg_lo = '0; cfg_hi = '0;
      recv_val = 1'b0; send_rdy = 1'b1;
      f1 = mkf(500, 1000, 1001, 2000, 0, 999, 1500, 32'hFFFF_FFFF);
      f2 = mkf(50, 100, 101, 200, 299, 300, 301, 250);
      for (int i = 0; i < 8; i++) recv_msg[i] = '0;

      tbl[0] = '{mode: 2'd0, lo: 1000, hi: 32'hFFFF_FFFF, fr: f1, emask: 8'b1100_1100, ecount: 4};
      tbl[1] = '{mode: 2'd2, lo: 100,  hi: 300,           fr: f2, emask: 8'b1001_1100, ecount: 4};
      tbl[2] = '{mode: 2'd2, lo: 300,  hi: 100,           fr: f2, emask: 8'h00,        ecount: 0};
      tbl[3] = '{mode: 2'd3, lo: 300,  hi: 100,           fr: f1, emask: 8'hFF,        ecount: 8};
      tbl[4] = '{mode: 2'd1, lo: 0,    hi: 1000,          fr: f1, emask: 8'b0011_0001, ecount: 3};

      repeat (2) @(posedge clk);
      #1 reset = 1'b0;
      check("rst_recv_rdy", recv_rdy, 1);
      check("rst_send_val", send_val, 0);
      check("rst_mask", send_mask, 0);
      check("rst_count", send_count, 0);

      // Reset-default cutoffs; accept cycle counts as cycle 1, so send_val is up 4 edges later.
      run_frame(f1, m, c, lat);
      check("dflt_mask", m, 8'b1100_1100);
      check("dflt_count", c, 4);
      check("dflt_latency", lat, 4);
      check("post_hs_send_val", send_val, 0);
      check("post_hs_recv_rdy", recv_rdy, 1);
      check("post_hs_mask_held", send_mask, 8'b1100_1100);

      foreach (tbl[i]) begin
         do_cfg(tbl[i].mode, tbl[i].lo, tbl[i].hi);
         run_frame(tbl[i].fr, m, c, lat);
         check($sformatf("tbl%0d_mask", i), m, tbl[i].emask);
         check($sformatf("tbl%0d_count", i), c, tbl[i].ecount);
      end

      // cfg_val coincident with the accepting edge must not affect that frame.
      fs = mkf(5, 2000, 9, 11, 1001, 0, 10, 3000);
      do_cfg(2'd0, 1000, 32'hFFFF_FFFF);
      cfg_val = 1'b1; cfg_mode = 2'd1; cfg_lo = 1000; cfg_hi = 10;
      run_frame(fs, m, c, lat);
      model(2'd0, 1000, 32'hFFFF_FFFF, fs, em, ec);
      check("samecyc_old_mask", m, em);
      check("samecyc_old_count", c, ec);
      run_frame(fs, m, c, lat);
      model(2'd1, 1000, 10, fs, em, ec);
      check("samecyc_new_mask", m, em);
      check("samecyc_new_count", c, ec);

      // Backpressure: hold DONE for 5 cycles while offering another frame.
      do_cfg(2'd2, 100, 300);
      send_rdy = 1'b0;
      recv_msg = f2; recv_val = 1'b1;
      @(posedge clk); #1;
      recv_val = 1'b0;
      lat = 0;
      while (!send_val && lat < 50) begin @(posedge clk); #1; lat++; end
      check("bp_send_val", send_val, 1);
      recv_msg = f1; recv_val = 1'b1;
      for (int k = 0; k < 5; k++) begin
         @(posedge clk); #1;
         check($sformatf("bp_hold%0d_mask", k), send_mask, 8'b1001_1100);
         check($sformatf("bp_hold%0d_count", k), send_count, 4);
         check($sformatf("bp_hold%0d_recv_rdy", k), recv_rdy, 0);
         check($sformatf("bp_hold%0d_send_val", k), send_val, 1);
      end
      send_rdy = 1'b1;
      @(posedge clk); #1;
      check("bp_release_send_val", send_val, 0);
      check("bp_release_recv_rdy", recv_rdy, 1);
      @(posedge clk); #1;
      recv_val = 1'b0;
      check("bp_next_accepted", recv_rdy, 0);
      lat = 0;
      while (!send_val && lat < 50) begin @(posedge clk); #1; lat++; end
      model(2'd2, 100, 300, f1, em, ec);
      check("bp_next_mask", send_mask, em);
      check("bp_next_count", send_count, ec);
      @(posedge clk); #1;

      // Reset while CALC is on its second step.
      do_cfg(2'd3, 5, 6);
      recv_msg = f1; recv_val = 1'b1;
      @(posedge clk); #1;
      recv_val = 1'b0;
      @(posedge clk); #1;
      reset = 1'b1;
      @(posedge clk); #1;
      reset = 1'b0;
      check("midrst_send_val", send_val, 0);
      check("midrst_recv_rdy", recv_rdy, 1);
      check("midrst_mask", send_mask, 0);
      check("midrst_count", send_count, 0);
      run_frame(f1, m, c, lat);
      check("midrst_dflt_mask", m, 8'b1100_1100);
      check("midrst_dflt_count", c, 4);

      for (int t = 0; t < 30; t++) begin
         rmode = 2'($urandom_range(0, 3));
         rlo   = $urandom_range(0, 400);
         rhi   = $urandom_range(0, 400);
         for (int i = 0; i < 8; i++) begin
            case ($urandom_range(0, 5))
               0: fr[i] = rlo;
               1: fr[i] = rhi;
               2: fr[i] = $urandom;
               default: fr[i] = $urandom_range(0, 400);
            endcase
         end
         do_cfg(rmode, rlo, rhi);
         run_frame(fr, m, c, lat);
         model(rmode, rlo, rhi, fr, em, ec);
         check($sformatf("rnd%0d_mask", t), m, em);
         check($sformatf("rnd%0d_count", t), c, ec);
      end

      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule
